// File: rtl/updown_counter_pkg.sv
// Shared constants and small helpers for the modulo up/down counter.
// Direction and boundary-mode encodings match the ud and sat input levels.
package updown_counter_pkg;

   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Sticky flag update: a set in the same cycle as a clear takes priority.
   function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
      return set | (cur & ~clr);
   endfunction

endpackage

// File: rtl/updown_counter_mod_next.sv
// Combinational next-state and boundary-event logic for updown_counter_mod.
// Arithmetic is carried one bit wider than q so MODULUS = 2**WIDTH wraps cleanly.
module updown_next
   import updown_counter_pkg::*;
#(
   parameter int              WIDTH   = 4,
   parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
   input  logic [WIDTH-1:0] q,
   input  logic             en,
   input  logic             ud,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_q,
   output logic             tc,
   output logic             wrap_evt,
   output logic             ovf_evt,
   output logic             unf_evt
);

   localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 64'd1);
   localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] ZERO = {(WIDTH+1){1'b0}};

   logic [WIDTH:0] q_ext_s;
   logic [WIDTH:0] d_ext_s;
   logic [WIDTH:0] sum_up_s;
   logic [WIDTH:0] diff_dn_s;
   logic           up_edge_s;
   logic           dn_edge_s;

   assign q_ext_s   = {1'b0, q};
   assign d_ext_s   = {1'b0, d};
   assign sum_up_s  = q_ext_s + ONE;
   assign diff_dn_s = q_ext_s - ONE;
   // The up boundary is reached when q+1 would leave the range; the down boundary when q-1 borrows.
   assign up_edge_s = (sum_up_s > LAST);
   assign dn_edge_s = diff_dn_s[WIDTH];

   // Terminal count looks only at q and the current direction.
   always_comb begin
      tc = 1'b0;
      if (ud == DIR_UP) begin
         tc = (q_ext_s == LAST);
      end else begin
         tc = (q_ext_s == ZERO);
      end
   end

   // Next count and boundary events; load has priority over counting.
   always_comb begin
      next_q   = q;
      wrap_evt = 1'b0;
      ovf_evt  = 1'b0;
      unf_evt  = 1'b0;
      if (load) begin
         if (d_ext_s > LAST) begin
            next_q = LAST[WIDTH-1:0];
         end else begin
            next_q = d;
         end
      end else if (en) begin
         if (ud == DIR_UP) begin
            if (up_edge_s) begin
               ovf_evt = 1'b1;
               if (sat == MODE_WRAP) begin
                  next_q   = ZERO[WIDTH-1:0];
                  wrap_evt = 1'b1;
               end else begin
                  next_q = q;
               end
            end else begin
               next_q = sum_up_s[WIDTH-1:0];
            end
         end else begin
            if (dn_edge_s) begin
               unf_evt = 1'b1;
               if (sat == MODE_WRAP) begin
                  next_q   = LAST[WIDTH-1:0];
                  wrap_evt = 1'b1;
               end else begin
                  next_q = q;
               end
            end else begin
               next_q = diff_dn_s[WIDTH-1:0];
            end
         end
      end else begin
         next_q = q;
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Modulo-MODULUS up/down counter with load, wrap/saturate modes and sticky boundary flags.
// This level holds only the state registers; all next-state decisions live in updown_next.
module updown_counter_mod
   import updown_counter_pkg::*;
#(
   parameter int              WIDTH   = 4,
   parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ud,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf_sticky,
   output logic             unf_sticky
);

   generate
      if ((WIDTH < 2) || (WIDTH > 32) || (MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_params
         $error("updown_counter_mod: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   logic [WIDTH-1:0] q_r;
   logic             wrap_r;
   logic             ovf_r;
   logic             unf_r;

   logic [WIDTH-1:0] next_q_s;
   logic             wrap_evt_s;
   logic             ovf_evt_s;
   logic             unf_evt_s;

   updown_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .q        (q_r),
      .en       (en),
      .ud       (ud),
      .sat      (sat),
      .load     (load),
      .d        (d),
      .next_q   (next_q_s),
      .tc       (tc),
      .wrap_evt (wrap_evt_s),
      .ovf_evt  (ovf_evt_s),
      .unf_evt  (unf_evt_s)
   );

   // Count, wrap pulse and sticky flags; reset overrides every other control.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r    <= {WIDTH{1'b0}};
         wrap_r <= 1'b0;
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
      end else begin
         q_r    <= next_q_s;
         wrap_r <= wrap_evt_s;
         ovf_r  <= sticky_next(ovf_r, ovf_evt_s, clr_flags);
         unf_r  <= sticky_next(unf_r, unf_evt_s, clr_flags);
      end
   end

   assign q          = q_r;
   assign wrap       = wrap_r;
   assign ovf_sticky = ovf_r;
   assign unf_sticky = unf_r;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Randomized and directed bench for updown_counter_mod, checking a MODULUS=10 and a MODULUS=16 build
// against an integer reference model driven by the same inputs.
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       ud = 1'b0;
   logic       sat = 1'b0;
   logic       load = 1'b0;
   logic [3:0] d = 4'd0;
   logic       clr_flags = 1'b0;

   logic [3:0] q0, q1;
   logic       tc0, tc1, wrap0, wrap1, ovf0, ovf1, unf0, unf1;

   int errors = 0;
   int checks = 0;

   int mod_v [2] = '{10, 16};
   int m_q   [2];
   int m_wrap[2];
   int m_ovf [2];
   int m_unf [2];

   always #5 clk = ~clk;

   updown_counter_mod #(.WIDTH(4), .MODULUS(64'd10)) dut10 (
      .clk(clk), .rst(rst), .en(en), .ud(ud), .sat(sat), .load(load), .d(d),
      .clr_flags(clr_flags), .q(q0), .tc(tc0), .wrap(wrap0), .ovf_sticky(ovf0), .unf_sticky(unf0)
   );

   updown_counter_mod #(.WIDTH(4), .MODULUS(64'd16)) dut16 (
      .clk(clk), .rst(rst), .en(en), .ud(ud), .sat(sat), .load(load), .d(d),
      .clr_flags(clr_flags), .q(q1), .tc(tc1), .wrap(wrap1), .ovf_sticky(ovf1), .unf_sticky(unf1)
   );

   function automatic logic [7:0] dut_obs(input int k);
      if (k == 0) return {q0, tc0, wrap0, ovf0, unf0};
      else        return {q1, tc1, wrap1, ovf1, unf1};
   endfunction

   // Expected {q, tc, wrap, ovf, unf} for instance k given the current ud.
   function automatic logic [7:0] mdl_obs(input int k);
      logic [3:0] qv;
      logic       t;
      qv = 4'(m_q[k]);
      t  = ud ? (m_q[k] == 0) : (m_q[k] == mod_v[k] - 1);
      return {qv, t, m_wrap[k] != 0, m_ovf[k] != 0, m_unf[k] != 0};
   endfunction

   // Apply the current inputs to the model, then take one clock edge.
   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         int hit_up, hit_dn, nxt;
         hit_up = 0;
         hit_dn = 0;
         if (rst) begin
            m_q[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
         end else begin
            m_wrap[k] = 0;
            if (load) begin
               m_q[k] = (int'(d) >= mod_v[k]) ? mod_v[k] - 1 : int'(d);
            end else if (en) begin
               nxt = ud ? m_q[k] - 1 : m_q[k] + 1;
               if (nxt >= mod_v[k] || nxt < 0) begin
                  hit_up = (nxt >= mod_v[k]) ? 1 : 0;
                  hit_dn = (nxt < 0) ? 1 : 0;
                  if (!sat) begin
                     m_q[k]    = (nxt + mod_v[k]) % mod_v[k];
                     m_wrap[k] = 1;
                  end
               end else begin
                  m_q[k] = nxt;
               end
            end
            m_ovf[k] = (hit_up != 0 || (m_ovf[k] != 0 && !clr_flags)) ? 1 : 0;
            m_unf[k] = (hit_dn != 0 || (m_unf[k] != 0 && !clr_flags)) ? 1 : 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; en = 1'b0; load = 1'b0; clr_flags = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; en = 1'b1; d = 4'd5; clr_flags = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (dut_obs(k) !== mdl_obs(k)) begin
            errors++;
            $display("FAIL reset[%0d] got=%h exp=%h", k, dut_obs(k), mdl_obs(k));
         end
      end
      checks++;
      if ({q0, wrap0, ovf0, unf0} !== 7'd0) begin
         errors++;
         $display("FAIL reset_zero got=%h exp=0", {q0, wrap0, ovf0, unf0});
      end
      idle();
   endtask

   task automatic test_count_up();
      int exp_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      rst = 1'b1;
      tick();
      idle();
      en = 1'b1; ud = 1'b0; sat = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (q0 !== 4'(exp_seq[i]) || wrap0 !== (exp_seq[i] == 0)) begin
            errors++;
            $display("FAIL count_up step %0d q=%0d wrap=%b exp q=%0d", i, q0, wrap0, exp_seq[i]);
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_obs(k) !== mdl_obs(k)) begin
               errors++;
               $display("FAIL count_up[%0d] step %0d got=%h exp=%h", k, i, dut_obs(k), mdl_obs(k));
            end
         end
      end
      checks++;
      if (ovf0 !== 1'b1) begin
         errors++;
         $display("FAIL count_up_ovf got=%b exp=1", ovf0);
      end
      idle();
   endtask

   task automatic test_sat_down();
      int exp_seq [5] = '{1, 0, 0, 0, 0};
      load = 1'b1; d = 4'd2;
      tick();
      idle();
      en = 1'b1; ud = 1'b1; sat = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (q0 !== 4'(exp_seq[i]) || wrap0 !== 1'b0 || tc0 !== (exp_seq[i] == 0)) begin
            errors++;
            $display("FAIL sat_down step %0d q=%0d wrap=%b tc=%b exp q=%0d", i, q0, wrap0, tc0, exp_seq[i]);
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_obs(k) !== mdl_obs(k)) begin
               errors++;
               $display("FAIL sat_down[%0d] step %0d got=%h exp=%h", k, i, dut_obs(k), mdl_obs(k));
            end
         end
      end
      checks++;
      if (unf0 !== 1'b1) begin
         errors++;
         $display("FAIL sat_down_unf got=%b exp=1", unf0);
      end
      idle();
   endtask

   task automatic test_load_clamp();
      logic [1:0] flags_before;
      flags_before = {ovf0, unf0};
      load = 1'b1; d = 4'd13; ud = 1'b0;
      tick();
      checks++;
      if (q0 !== 4'd9 || wrap0 !== 1'b0 || {ovf0, unf0} !== flags_before || q1 !== 4'd13) begin
         errors++;
         $display("FAIL load_clamp q10=%0d q16=%0d wrap=%b exp q10=9 q16=13 wrap=0", q0, q1, wrap0);
      end
      d = 4'd0;
      tick();
      idle();
      en = 1'b1; ud = 1'b1; sat = 1'b0;
      tick();
      checks++;
      if (q0 !== 4'd9 || wrap0 !== 1'b1 || q1 !== 4'd15 || wrap1 !== 1'b1) begin
         errors++;
         $display("FAIL down_wrap q10=%0d w=%b q16=%0d w=%b exp 9/1 15/1", q0, wrap0, q1, wrap1);
      end
      en = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (dut_obs(k) !== mdl_obs(k)) begin
            errors++;
            $display("FAIL wrap_one_cycle[%0d] got=%h exp=%h", k, dut_obs(k), mdl_obs(k));
         end
      end
      idle();
   endtask

   task automatic test_priority();
      load = 1'b1; en = 1'b1; d = 4'd5; ud = 1'b0;
      tick();
      checks++;
      if (q0 !== 4'd5 || q1 !== 4'd5) begin
         errors++;
         $display("FAIL load_vs_en q10=%0d q16=%0d exp 5", q0, q1);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (q0 !== 4'd0 || q1 !== 4'd0) begin
         errors++;
         $display("FAIL rst_vs_load q10=%0d q16=%0d exp 0", q0, q1);
      end
      idle();
   endtask

   task automatic test_clr_flags();
      load = 1'b1; d = 4'd9;
      tick();
      load = 1'b0; en = 1'b1; ud = 1'b0; sat = 1'b0; clr_flags = 1'b1;
      tick();
      checks++;
      if (q0 !== 4'd0 || wrap0 !== 1'b1 || ovf0 !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_set q=%0d wrap=%b ovf=%b exp 0/1/1", q0, wrap0, ovf0);
      end
      en = 1'b0;
      tick();
      checks++;
      if (ovf0 !== 1'b0 || unf0 !== 1'b0 || ovf1 !== 1'b0 || unf1 !== 1'b0) begin
         errors++;
         $display("FAIL clr_alone flags=%b%b%b%b exp 0000", ovf0, unf0, ovf1, unf1);
      end
      idle();
   endtask

   task automatic test_mod16_wrap();
      load = 1'b1; d = 4'd15;
      tick();
      load = 1'b0; en = 1'b1; ud = 1'b0; sat = 1'b0;
      tick();
      checks++;
      if (q1 !== 4'd0 || wrap1 !== 1'b1 || ovf1 !== 1'b1) begin
         errors++;
         $display("FAIL mod16_wrap q=%0d wrap=%b ovf=%b exp 0/1/1", q1, wrap1, ovf1);
      end
      tick();
      checks++;
      if (q1 !== 4'd1 || wrap1 !== 1'b0) begin
         errors++;
         $display("FAIL mod16_after q=%0d wrap=%b exp 1/0", q1, wrap1);
      end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         load      = ($urandom_range(0, 7) == 0);
         en        = ($urandom_range(0, 3) != 0);
         ud        = $urandom_range(0, 1) != 0;
         sat       = ($urandom_range(0, 2) == 0);
         clr_flags = ($urandom_range(0, 9) == 0);
         d         = 4'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_obs(k) !== mdl_obs(k)) begin
               errors++;
               $display("FAIL random[%0d] cycle %0d got=%h exp=%h", k, i, dut_obs(k), mdl_obs(k));
            end
         end
      end
      idle();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_q[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end
      test_reset();
      test_count_up();
      test_sat_down();
      test_load_clamp();
      test_priority();
      test_clr_flags();
      test_mod16_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/updown_counter_mod.md
UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 2**WIDTH, giving the count range 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port ud, input, 1 bit: direction, 0 = up, 1 = down.
REQ-007 The block SHALL have port sat, input, 1 bit: boundary mode, 0 = wrap, 1 = saturate.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port d, input, WIDTH bits: load value.
REQ-010 The block SHALL have port clr_flags, input, 1 bit: clears the sticky flags.
REQ-011 The block SHALL have port q, output, WIDTH bits: the registered count.
REQ-012 The block SHALL have port tc, output, 1 bit: terminal count, combinational from q and ud.
REQ-013 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on a wrap event.
REQ-014 The block SHALL have port ovf_sticky, output, 1 bit: sticky flag for an up-direction boundary hit.
REQ-015 The block SHALL have port unf_sticky, output, 1 bit: sticky flag for a down-direction boundary hit.

Function
REQ-016 Per-edge priority SHALL be: rst, then load, then en; with none of these asserted, q SHALL hold.
REQ-017 When load=1, q SHALL become d on the next edge, or MODULUS-1 if d >= MODULUS; a load SHALL never raise wrap or set a sticky flag.
REQ-018 When en=1 and load=0, q SHALL become q+1 if ud=0 or q-1 if ud=1, taking effect on the next edge (latency 1).
REQ-019 Up boundary, q = MODULUS-1: with sat=0, q SHALL become 0, wrap SHALL be 1 for one cycle, and ovf_sticky SHALL be set; with sat=1, q SHALL hold, wrap SHALL stay 0, and ovf_sticky SHALL be set.
REQ-020 Down boundary, q = 0: with sat=0, q SHALL become MODULUS-1, wrap SHALL be 1 for one cycle, and unf_sticky SHALL be set; with sat=1, q SHALL hold and unf_sticky SHALL be set.
REQ-021 tc SHALL be 1 when (ud=0 and q=MODULUS-1) or (ud=1 and q=0), independent of en.
REQ-022 wrap SHALL be registered and aligned with the q update that wraps; it SHALL be 0 on every other cycle.
REQ-023 If clr_flags and a flag-setting event occur in the same cycle, the set SHALL win; clr_flags alone SHALL clear both sticky flags on the next edge.
REQ-024 ud and sat SHALL be sampled every cycle; a direction change takes effect on the next counting edge with no dead cycle.
REQ-025 Arithmetic SHALL use WIDTH+1 bits internally; q SHALL never hold a value >= MODULUS, including when MODULUS = 2**WIDTH.

Reset
REQ-026 On rst=1 at an edge, q SHALL become 0 and wrap, ovf_sticky and unf_sticky SHALL become 0, overriding load, en and clr_flags.
REQ-027 A reset asserted mid-count SHALL take effect on that edge, and counting SHALL resume from 0 on the first edge after rst is released.

Structure
REQ-028 Package updown_counter_pkg SHALL hold the direction constants (DIR_UP=0, DIR_DOWN=1) and the mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-029 The next-value and boundary logic SHALL be a combinational sub-module, updown_next, which returns the next q, wrap_evt, ovf_evt and unf_evt; the top level SHALL hold only the registers.
REQ-030 Illegal parameter values SHALL be rejected at elaboration.

Verification (WIDTH=4, MODULUS=10)
REQ-031 Scenario: rst, then en=1, ud=0, sat=0 for 12 cycles -> q runs 1..9, 0, 1, 2; wrap is high exactly on the cycle q=0; ovf_sticky=1.
REQ-032 Scenario: load d=2, then ud=1, sat=1, en=1 for 5 cycles -> q runs 1, 0, 0, 0, 0; wrap never asserts; unf_sticky=1; tc=1 while q=0.
REQ-033 Scenario: load d=13 -> q=9, no wrap, flags unchanged; then ud=1, sat=0 at q=0 -> q=9 with a wrap pulse.
REQ-034 Scenario: load=1 and en=1 in the same cycle with d=5 -> q=5 (load wins); rst=1 together with load=1 -> q=0.
REQ-035 Scenario: clr_flags=1 in the same cycle as a wrap from 9 to 0 -> ovf_sticky stays 1; clr_flags alone on the next cycle -> both flags 0.
REQ-036 Scenario: MODULUS=16 build, count up from 15 -> q=0 with a wrap pulse; confirm no overflow into bit 4.
